// File: rtl/keypad_scanner.sv
// keypad_scanner
// Purpose: scans a ROWS x COLS matrix keypad. One row is driven low at a
//   time. The column inputs are synchronised and then sampled. A single key
//   is debounced, and an accepted press puts a key code
//   (row_index*COLS + col_index) into a small first-word-fall-through FIFO.
//   Release is debounced as well. While a key is held, the row drive stays
//   frozen on that key's row.
// Optional feature: define KPD_TYPEMATIC_EN to auto-repeat a held key.
//   The first repeat comes REPEAT_DELAY cycles after acceptance, and later
//   repeats come every REPEAT_PERIOD cycles.
// Ports:
//   clk       in   rising-edge system clock
//   reset     in   asynchronous, active-high reset
//   col_n     in   [COLS] raw keypad columns, active-low, asynchronous to clk
//   row_n     out  [ROWS] row drive, exactly one bit low
//   key_code  out  [CODE_W] FIFO head code, 0 when the FIFO is empty
//   key_valid out  FIFO not empty
//   key_ready in   consumer accepts the head when key_valid is high
//   key_down  out  high while an accepted key is held
//   overflow  out  sticky, set when a code was dropped on a full FIFO
module keypad_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 16,
  localparam int CODE_W = ($clog2(ROWS*COLS) > 1) ? $clog2(ROWS*COLS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COLS-1:0]   col_n,
  output logic [ROWS-1:0]   row_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_down,
  output logic              overflow
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES);
  localparam logic [AW:0] PTR_ONE = 1;

  // Parameter sanity checks, evaluated at elaboration only
  if (ROWS < 2 || ROWS > 8) begin : g_bad_rows
    $error("keypad_scanner: ROWS must be 2..8");
  end
  if (COLS < 2 || COLS > 8) begin : g_bad_cols
    $error("keypad_scanner: COLS must be 2..8");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_deb
    $error("keypad_scanner: DEBOUNCE_CYCLES must be 1..255");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
    $error("keypad_scanner: FIFO_DEPTH must be a power of two >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY > 65535 ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > 65535) begin : g_bad_rep
    $error("keypad_scanner: REPEAT_DELAY/REPEAT_PERIOD must be 1..65535");
  end

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HELD} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d, row_next;
  logic [ROWS-1:0]   row_n_q, row_n_d;
  logic [1:0]        phase_q, phase_d;
  logic [CW-1:0]     col_q, col_d, low_idx;
  logic [7:0]        cnt_q, cnt_d, cnt_inc;
  logic              key_down_q, key_down_d;
  logic [COLS-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic              col_low, any_low, accept, push;
  logic [CODE_W-1:0] push_code;

`ifdef KPD_TYPEMATIC_EN
  localparam logic [15:0] REP_DELAY  = 16'(REPEAT_DELAY);
  localparam logic [15:0] REP_PERIOD = 16'(REPEAT_PERIOD);
  logic [15:0] rep_q, rep_d, rep_inc;
  logic        rep_phase_q, rep_phase_d;
`endif

  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [CODE_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic              overflow_q, overflow_d;
  logic              empty, full, pop, push_ok;

  // Two-flop synchroniser for the asynchronous column inputs
  always_comb begin
    sync1_d = col_n;
    sync2_d = sync1_q;
  end

  assign push_code = CODE_W'(row_q) * CODE_W'(COLS) + CODE_W'(col_q);

  // Scan / debounce / held controller
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    phase_d    = phase_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    key_down_d = key_down_q;
    accept     = 1'b0;
    push       = 1'b0;
`ifdef KPD_TYPEMATIC_EN
    rep_d       = rep_q;
    rep_phase_d = rep_phase_q;
    rep_inc     = rep_q + 16'd1;
`endif
    row_next = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    cnt_inc  = cnt_q + 8'd1;
    col_low  = ~sync2_q[col_q];
    any_low  = ~&sync2_q;
    // When several columns are low at once, the lowest-index one wins
    low_idx  = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!sync2_q[i]) low_idx = CW'(i);
    end

    case (state_q)
      ST_SCAN: begin
        if (phase_q == 2'd2) begin
          phase_d = '0;
          if (any_low) begin
            col_d = low_idx;
            // With a one-sample debounce, the scan sample itself accepts the key
            if (DEBOUNCE_CYCLES == 1) begin
              accept = 1'b1;
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = 8'd1;
            end
          end else begin
            row_d = row_next;
          end
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      ST_DEBOUNCE: begin
        if (col_low) begin
          if (cnt_inc == DEB_LAST) accept = 1'b1;
          else                     cnt_d  = cnt_inc;
        end else begin
          state_d = ST_SCAN;
          row_d   = row_next;
          phase_d = '0;
          cnt_d   = '0;
        end
      end
      ST_HELD: begin
        if (col_low) begin
          cnt_d = '0;
`ifdef KPD_TYPEMATIC_EN
          // The repeat timer waits while a release is in progress and
          // starts again from zero if the key bounces back low
          if (cnt_q != '0) begin
            rep_d = '0;
          end else begin
            rep_d = rep_inc;
            if ((!rep_phase_q && rep_inc == REP_DELAY) ||
                ( rep_phase_q && rep_inc == REP_PERIOD)) begin
              push        = 1'b1;
              rep_d       = '0;
              rep_phase_d = 1'b1;
            end
          end
`endif
        end else if (cnt_inc == DEB_LAST) begin
          state_d    = ST_SCAN;
          row_d      = row_next;
          phase_d    = '0;
          cnt_d      = '0;
          key_down_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_SCAN;
        row_d   = '0;
        phase_d = '0;
        cnt_d   = '0;
      end
    endcase

    if (accept) begin
      push       = 1'b1;
      state_d    = ST_HELD;
      cnt_d      = '0;
      key_down_d = 1'b1;
`ifdef KPD_TYPEMATIC_EN
      rep_d       = '0;
      rep_phase_d = 1'b0;
`endif
    end

    row_n_d = ~(ROWS'(1) << row_d);
  end

  // FIFO pointers use one extra wrap bit so full and empty can be told apart
  always_comb begin
    empty      = (wr_q == rd_q);
    full       = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
    pop        = ~empty & key_ready;
    push_ok    = push & (~full | pop);
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    overflow_d = overflow_q | (push & ~push_ok);
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = push_code;
      wr_d                = wr_q + PTR_ONE;
    end
    if (pop) rd_d = rd_q + PTR_ONE;
  end

  assign key_valid = ~empty;
  assign key_code  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign row_n     = row_n_q;
  assign key_down  = key_down_q;
  assign overflow  = overflow_q;

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SCAN;
      row_q      <= '0;
      row_n_q    <= ~ROWS'(1);
      phase_q    <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      key_down_q <= 1'b0;
      sync1_q    <= '1;
      sync2_q    <= '1;
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
`ifdef KPD_TYPEMATIC_EN
      rep_q       <= '0;
      rep_phase_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      row_n_q    <= row_n_d;
      phase_q    <= phase_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      key_down_q <= key_down_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      overflow_q <= overflow_d;
`ifdef KPD_TYPEMATIC_EN
      rep_q       <= rep_d;
      rep_phase_q <= rep_phase_d;
`endif
    end
  end

endmodule
